spi_slave_regs: RTL and testbench

SPI slave endpoint sitting directly downstream of `spi_top`: it consumes `ss0`/`sclk`/`mosi`, drives `miso`, and exposes a small register file (8 × 8-bit) to local logic. It runs entirely on the system clock, oversampling the SPI pins, and implements SPI mode 0 (CPOL=0, CPHA=0), MSB first. It is the bench-side and on-board counterpart used to close the loop on the SPI master.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_slave_regs_if.sv | 21 ++
 rtl/spi_sync.sv | 23 ++
 rtl/spi_slave_regs.sv | 95 +++++++++
 tb/tb_spi_slave_regs.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, command layout and FSM states for the SPI register slave
package spi_pkg;
    localparam int DATA        = 8;
    localparam int ADDRESS     = 3;
    localparam int REGS        = 1 << ADDRESS;
    localparam int CNT_W       = $clog2(DATA);
    localparam int CMD_WR_BIT  = 7;
    localparam int SYNC_STAGES = 2;
    typedef enum logic [1:0] {IDLE, CMD, DATA_ST} state_t;
endpackage

// File: rtl/spi_slave_regs_if.sv
// spi_slave_regs_if: SPI pins plus the local write-notify and read port of the register slave
interface spi_slave_regs_if;
    import spi_pkg::*;
    logic               ss;
    logic               sclk;
    logic               mosi;
    logic               miso;
    logic               wr_strobe;
    logic [ADDRESS-1:0] wr_addr;
    logic [DATA-1:0]    wr_data;
    logic [ADDRESS-1:0] loc_addr;
    logic [DATA-1:0]    loc_rdata;
    modport slave (
        input  ss, sclk, mosi, loc_addr,
        output miso, wr_strobe, wr_addr, wr_data, loc_rdata
    );
    modport master (
        output ss, sclk, mosi, loc_addr,
        input  miso, wr_strobe, wr_addr, wr_data, loc_rdata
    );
endinterface

// File: rtl/spi_sync.sv
// spi_sync: two-flop synchronizer with a third flop for one-PCLK rise/fall pulses
module spi_sync
    import spi_pkg::*;
#(
    parameter logic INIT = 1'b0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES:0] s;
    // shift the asynchronous pin through the synchronizer and edge-detect stage
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) s <= {(SYNC_STAGES + 1){INIT}};
        else          s <= {s[SYNC_STAGES-1:0], d};
    end
    assign level = s[SYNC_STAGES-1];
    assign rise  = s[SYNC_STAGES-1] & ~s[SYNC_STAGES];
    assign fall  = ~s[SYNC_STAGES-1] & s[SYNC_STAGES];
endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: oversampled SPI mode-0 slave exposing an 8x8 register file
module spi_slave_regs
    import spi_pkg::*;
(
    input logic             PCLK,
    input logic             PRESETn,
    spi_slave_regs_if.slave bus
);
    state_t             state, state_d;
    logic               ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_lvl;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA-1:0]    rx, tx, rx_next, wr_data_q;
    logic [DATA-1:0]    regs [REGS];
    logic [ADDRESS-1:0] addr, addr_inc, cmd_addr, rd_sel, wr_addr_q;
    logic               wr_mode, active, byte_done, rd_load, miso_q, wr_strobe_q;

    spi_sync #(.INIT(1'b1)) u_ss   (.PCLK(PCLK), .PRESETn(PRESETn), .d(bus.ss),   .level(), .rise(ss_rise),   .fall(ss_fall));
    spi_sync #(.INIT(1'b0)) u_sclk (.PCLK(PCLK), .PRESETn(PRESETn), .d(bus.sclk), .level(), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync #(.INIT(1'b0)) u_mosi (.PCLK(PCLK), .PRESETn(PRESETn), .d(bus.mosi), .level(mosi_lvl), .rise(), .fall());

    // an ss rise wins over any sclk edge seen in the same cycle
    assign active    = (state != IDLE) && !ss_rise;
    assign rx_next   = {rx[DATA-2:0], mosi_lvl};
    assign byte_done = active && sclk_rise && (&bit_cnt);
    assign cmd_addr  = rx_next[ADDRESS-1:0];
    assign addr_inc  = addr + ADDRESS'(1);
    assign rd_sel    = (state == CMD) ? cmd_addr : addr_inc;
    assign rd_load   = (state == CMD) ? !rx_next[CMD_WR_BIT] : !wr_mode;

    // frame state register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_d;
    end

    // next state: ss edges frame the transfer, the command byte moves us to data
    always_comb begin
        state_d = ss_rise ? IDLE :
                  ss_fall ? CMD :
                  (state == CMD && byte_done) ? DATA_ST : state;
    end

    // shifters, bit counter, address pointer and register file
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            addr        <= '0;
            wr_mode     <= 1'b0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            regs        <= '{default: '0};
        end else begin
            wr_strobe_q <= 1'b0;
            if (ss_fall) begin
                bit_cnt <= '0;
                rx      <= '0;
                tx      <= '0;
                miso_q  <= 1'b0;
            end else if (ss_rise) begin
                tx     <= '0;
                miso_q <= 1'b0;
            end else if (active && sclk_rise) begin
                rx      <= rx_next;
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (byte_done) begin
                    if (state == CMD) wr_mode <= rx_next[CMD_WR_BIT];
                    addr <= (state == CMD) ? cmd_addr : addr_inc;
                    if (state == DATA_ST && wr_mode) begin
                        regs[addr]  <= rx_next;
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= addr;
                        wr_data_q   <= rx_next;
                    end
                    if (rd_load) begin
                        tx     <= regs[rd_sel];
                        miso_q <= regs[rd_sel][DATA-1];
                    end
                end
            end else if (active && sclk_fall && bit_cnt != '0) begin
                tx     <= tx << 1;
                miso_q <= tx[DATA-2];
            end
        end
    end

    assign bus.miso      = miso_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.loc_rdata = regs[bus.loc_addr];
endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: bit-banged SPI master with scoreboarded write strobes and miso bytes
module tb_spi_slave_regs;
    import spi_pkg::*;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic [ADDRESS+DATA-1:0] wr_q[$];
    logic [DATA-1:0] rd_q[$];
    logic [DATA-1:0] lb [8];

    spi_slave_regs_if bus();
    spi_slave_regs dut (.PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            bus.mosi = b[7-i];
            clks(4);
            bus.sclk = 1'b1;
            clks(4);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_miso);
        rd_q.push_back(exp_miso);
        send_bits(b, 8);
    endtask

    task automatic exp_wr(input logic [ADDRESS-1:0] a, input logic [DATA-1:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic start();
        bus.ss = 1'b0;
        clks(4);
    endtask

    task automatic stop();
        clks(4);
        bus.ss = 1'b1;
        clks(8);
    endtask

    task automatic check_reg(input int a, input logic [7:0] exp);
        bus.loc_addr = ADDRESS'(a);
        #1;
        check($sformatf("loc_rdata[%0d]", a), 32'(bus.loc_rdata), 32'(exp));
    endtask

    // miso monitor: assemble each full byte on master sampling edges
    initial begin
        logic [7:0] sh;
        int n;
        sh = '0;
        n = 0;
        forever begin
            @(posedge bus.sclk or posedge bus.ss);
            if (bus.ss === 1'b1) n = 0;
            else begin
                sh = {sh[6:0], bus.miso};
                n++;
                if (n == 8) begin
                    n = 0;
                    if (rd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL miso_byte: got %0h with no byte expected", sh);
                    end else check("miso_byte", 32'(sh), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    // write-strobe monitor
    initial begin
        logic [ADDRESS+DATA-1:0] e;
        forever begin
            @(negedge PCLK);
            if (bus.wr_strobe === 1'b1) begin
                strobes++;
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_strobe: unexpected addr %0h data %0h", bus.wr_addr, bus.wr_data);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(bus.wr_addr), 32'(e[ADDRESS+DATA-1:DATA]));
                    check("wr_data", 32'(bus.wr_data), 32'(e[DATA-1:0]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        lb[0] = 8'hDE; lb[1] = 8'hAD; lb[2] = 8'hBE; lb[3] = 8'hEF;
        lb[4] = 8'h01; lb[5] = 8'h80; lb[6] = 8'h7F; lb[7] = 8'hC3;
        bus.ss = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.loc_addr = '0;
        clks(3);
        check("rst_miso", 32'(bus.miso), 0);
        check("rst_wr_strobe", 32'(bus.wr_strobe), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        for (int a = 0; a < 8; a++) check_reg(a, 8'h00);
        PRESETn = 1'b1;
        clks(4);
        // single write
        start();
        send_byte(8'h83, 8'h00);
        exp_wr(3'd3, 8'hA5);
        send_byte(8'hA5, 8'h00);
        stop();
        check_reg(3, 8'hA5);
        // burst write with address wrap
        start();
        send_byte(8'h86, 8'h00);
        exp_wr(3'd6, 8'h11);
        send_byte(8'h11, 8'h00);
        exp_wr(3'd7, 8'h22);
        send_byte(8'h22, 8'h00);
        exp_wr(3'd0, 8'h33);
        send_byte(8'h33, 8'h00);
        stop();
        check_reg(6, 8'h11);
        check_reg(7, 8'h22);
        check_reg(0, 8'h33);
        // read frame across the wrap
        start();
        send_byte(8'h07, 8'h00);
        send_byte(8'h00, 8'h22);
        send_byte(8'h00, 8'h33);
        stop();
        check("miso_idle", 32'(bus.miso), 0);
        // abort after five data bits
        start();
        send_byte(8'h82, 8'h00);
        send_bits(8'hFF, 5);
        stop();
        check_reg(2, 8'h00);
        // command-only frame does nothing
        start();
        send_byte(8'h85, 8'h00);
        stop();
        check_reg(5, 8'h00);
        // reset in the middle of a data byte
        start();
        send_byte(8'h84, 8'h00);
        send_bits(8'hFF, 3);
        PRESETn = 1'b0;
        #1;
        bus.ss = 1'b1;
        clks(2);
        check("mid_rst_miso", 32'(bus.miso), 0);
        check("mid_rst_wr_addr", 32'(bus.wr_addr), 0);
        check("mid_rst_wr_data", 32'(bus.wr_data), 0);
        check_reg(3, 8'h00);
        check_reg(6, 8'h00);
        check_reg(0, 8'h00);
        PRESETn = 1'b1;
        clks(8);
        start();
        send_byte(8'h81, 8'h00);
        exp_wr(3'd1, 8'h5A);
        send_byte(8'h5A, 8'h00);
        stop();
        check_reg(1, 8'h5A);
        // loopback of all eight registers, ignored command bits set
        start();
        send_byte(8'hD0, 8'h00);
        for (int a = 0; a < 8; a++) begin
            exp_wr(ADDRESS'(a), lb[a]);
            send_byte(lb[a], 8'h00);
        end
        stop();
        start();
        send_byte(8'h78, 8'h00);
        for (int a = 0; a < 8; a++) send_byte(8'h00, lb[a]);
        stop();
        for (int a = 0; a < 8; a++) check_reg(a, lb[a]);
        clks(10);
        check("wr_q_empty", 32'(wr_q.size()), 0);
        check("rd_q_empty", 32'(rd_q.size()), 0);
        check("strobe_count", 32'(strobes), 13);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
